// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, a one-entry skid buffer
// for decode stalls and branch redirect/flush.
module fetch_stage #(
   parameter int unsigned        ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter logic [31:0]        NOP_INSTR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              if_id_valid,
   output logic [31:0]       if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc4,
   output logic [5:0]        opcode,
   output logic [5:0]        func,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [15:0]       imm
);

   typedef enum logic {S_FETCH, S_FULL} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n, pc_inc;
   logic [31:0]       skid_instr, skid_instr_n;
   logic [ADDR_W-1:0] skid_pc4, skid_pc4_n;
   logic              valid_n;
   logic [31:0]       instr_n;
   logic [ADDR_W-1:0] pc4_n;

   assign pc_inc    = pc + ADDR_W'(4);
   assign imem_req  = rst_n && (state == S_FETCH);
   assign imem_addr = pc;

   assign opcode = if_id_instr[31:26];
   assign func   = if_id_instr[5:0];
   assign rs     = if_id_instr[25:21];
   assign rt     = if_id_instr[20:16];
   assign rd     = if_id_instr[15:11];
   assign imm    = if_id_instr[15:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_FETCH;
         pc          <= RESET_PC;
         skid_instr  <= NOP_INSTR;
         skid_pc4    <= '0;
         if_id_valid <= 1'b0;
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         skid_instr  <= skid_instr_n;
         skid_pc4    <= skid_pc4_n;
         if_id_valid <= valid_n;
         if_id_instr <= instr_n;
         if_id_pc4   <= pc4_n;
      end
   end

   // A branch flushes everything, even under stall; an ack in that cycle is dropped.
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      skid_instr_n = skid_instr;
      skid_pc4_n   = skid_pc4;
      valid_n      = if_id_valid;
      instr_n      = if_id_instr;
      pc4_n        = if_id_pc4;

      if (branch_taken) begin
         pc_n         = branch_target;
         state_n      = S_FETCH;
         skid_instr_n = NOP_INSTR;
         skid_pc4_n   = '0;
         valid_n      = 1'b0;
         instr_n      = NOP_INSTR;
         pc4_n        = '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_ack) begin
                  pc_n = pc_inc;
                  if (stall) begin
                     skid_instr_n = imem_rdata;
                     skid_pc4_n   = pc_inc;
                     state_n      = S_FULL;
                  end else begin
                     valid_n = 1'b1;
                     instr_n = imem_rdata;
                     pc4_n   = pc_inc;
                  end
               end else if (!stall) begin
                  valid_n = 1'b0;
                  instr_n = NOP_INSTR;
                  pc4_n   = '0;
               end
            end
            S_FULL: begin
               if (!stall) begin
                  valid_n      = 1'b1;
                  instr_n      = skid_instr;
                  pc4_n        = skid_pc4;
                  skid_instr_n = NOP_INSTR;
                  skid_pc4_n   = '0;
                  state_n      = S_FETCH;
               end
            end
            default: state_n = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns addr^32'hA5A5_0000
// unless an explicit instruction word is forced.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic [5:0]  opcode, func;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;

   logic        use_word = 1'b0;
   logic [31:0] forced_word = 32'h0;
   int          checks = 0;
   int          failures = 0;

   assign imem_rdata = use_word ? forced_word : (imem_addr ^ 32'hA5A5_0000);

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
      .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm(imm)
   );

   task automatic applyStimulus(input logic r, input logic ack, input logic st,
                                input logic br, input logic [31:0] tgt);
      rst_n         = r;
      imem_ack      = ack;
      stall         = st;
      branch_taken  = br;
      branch_target = tgt;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkIfId(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic [31:0] addr, input logic req);
      checkOutput({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
      checkOutput({tag, ".instr"}, if_id_instr, instr);
      checkOutput({tag, ".pc4"}, if_id_pc4, pc4);
      checkOutput({tag, ".addr"}, imem_addr, addr);
      checkOutput({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
   endtask

   initial begin
      // Reset
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      checkOutput("reset.opcode", {26'b0, opcode}, 32'h0);
      checkOutput("reset.imm", {16'b0, imm}, 32'h0);

      // Zero-wait memory, one instruction per cycle
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("zw0", 1'b1, 32'hA5A5_0000, 32'h4, 32'h4, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("zw1", 1'b1, 32'hA5A5_0004, 32'h8, 32'h8, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("zw2", 1'b1, 32'hA5A5_0008, 32'hC, 32'hC, 1'b1);

      // Ack every third cycle: two bubbles between instructions
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("sl0", 1'b0, 32'h0, 32'h0, 32'hC, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("sl1", 1'b0, 32'h0, 32'h0, 32'hC, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("sl2", 1'b1, 32'hA5A5_000C, 32'h10, 32'h10, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("sl3", 1'b0, 32'h0, 32'h0, 32'h10, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("sl4", 1'b0, 32'h0, 32'h0, 32'h10, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("sl5", 1'b1, 32'hA5A5_0010, 32'h14, 32'h14, 1'b1);

      // Stall for 3 cycles starting on an ack -> skid fills, then drains
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("st0", 1'b1, 32'hA5A5_0014, 32'h18, 32'h18, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      checkIfId("st1", 1'b1, 32'hA5A5_0014, 32'h18, 32'h1C, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      checkIfId("st2", 1'b1, 32'hA5A5_0014, 32'h18, 32'h1C, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      checkIfId("st3", 1'b1, 32'hA5A5_0014, 32'h18, 32'h1C, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("st4", 1'b1, 32'hA5A5_0018, 32'h1C, 32'h1C, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("st5", 1'b1, 32'hA5A5_001C, 32'h20, 32'h20, 1'b1);

      // Branch with ack and stall in the same cycle overrides both
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
      checkIfId("br0", 1'b0, 32'h0, 32'h0, 32'h40, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("br1", 1'b1, 32'hA5A5_0040, 32'h44, 32'h44, 1'b1);

      // Branch while the skid is full drops the skid word
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      checkIfId("bf0", 1'b1, 32'hA5A5_0040, 32'h44, 32'h48, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
      checkIfId("bf1", 1'b0, 32'h0, 32'h0, 32'h100, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("bf2", 1'b0, 32'h0, 32'h0, 32'h100, 1'b1);

      // Field decode: add $3,$4,$5 then lw $6,-16($5)
      use_word = 1'b1;
      forced_word = 32'h0085_1820;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("add", 1'b1, 32'h0085_1820, 32'h104, 32'h104, 1'b1);
      checkOutput("add.opcode", {26'b0, opcode}, 32'h0);
      checkOutput("add.func", {26'b0, func}, 32'h20);
      checkOutput("add.rs", {27'b0, rs}, 32'h4);
      checkOutput("add.rt", {27'b0, rt}, 32'h5);
      checkOutput("add.rd", {27'b0, rd}, 32'h3);
      checkOutput("add.imm", {16'b0, imm}, 32'h1820);
      forced_word = 32'h8CA6_FFF0;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("lw.opcode", {26'b0, opcode}, 32'h23);
      checkOutput("lw.func", {26'b0, func}, 32'h30);
      checkOutput("lw.rs", {27'b0, rs}, 32'h5);
      checkOutput("lw.rt", {27'b0, rt}, 32'h6);
      checkOutput("lw.rd", {27'b0, rd}, 32'h1F);
      checkOutput("lw.imm", {16'b0, imm}, 32'hFFF0);
      checkOutput("lw.pc4", if_id_pc4, 32'h108);
      use_word = 1'b0;

      // PC wrap and unaligned branch target
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      checkIfId("wr0", 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("wr1", 1'b1, 32'h5A5A_FFFC, 32'h0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h13);
      checkIfId("ua0", 1'b0, 32'h0, 32'h0, 32'h13, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("ua1", 1'b1, 32'hA5A5_0013, 32'h17, 32'h17, 1'b1);

      // Reset while the skid is full
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      checkIfId("rf0", 1'b1, 32'hA5A5_0013, 32'h17, 32'h1B, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkIfId("rf1", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkIfId("rf2", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkIfId("rf3", 1'b1, 32'hA5A5_0000, 32'h4, 32'h4, 1'b1);

      // Stall without ack holds IF/ID and keeps the request up
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      checkIfId("sn0", 1'b1, 32'hA5A5_0000, 32'h4, 32'h4, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
